// File: rtl/imu_pkg.sv
// ---------------------------------------------------------------------------
// imu_pkg
// Shared definitions for the IMU burst reader: the sequencer state encoding,
// the SPI read-command flag and the dummy byte clocked out while reading.
// ---------------------------------------------------------------------------
package imu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_ADDR     = 3'd2,
    ST_BYTE     = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_PUBLISH  = 3'd5
  } imu_state_e;

  // Bit 7 of the first byte selects a register read on the IMU.
  localparam logic [7:0] IMU_READ_BIT   = 8'h80;
  // Clocked out while the slave shifts data back.
  localparam logic [7:0] IMU_DUMMY_BYTE = 8'h00;

  function automatic logic [7:0] imu_read_cmd(input logic [7:0] addr);
    return addr | IMU_READ_BIT;
  endfunction

endpackage

// File: rtl/imu_burst_reader.sv
// ---------------------------------------------------------------------------
// imu_burst_reader
// On a trigger, selects the IMU, sends a burst-read command for START_ADDR,
// clocks in 2*NUM_AXES data bytes through an external SPI byte master, then
// deselects and publishes all axis words at once (axis 0 in the MSBs).
//
// Optional feature: define IMU_BURST_READER_TIMEOUT_EN to enable a watchdog
// that aborts the burst when spi_done does not arrive within TIMEOUT_CYC
// cycles of the last spi_start. Without it the block waits forever and
// timeout is constant low.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   trigger         single-cycle burst request
//   spi_start/tx    byte-transfer request and byte to send (to SPI master)
//   spi_rx/done     received byte and its completion strobe (from master)
//   spi_busy        SPI master busy
//   cs_n            slave chip select, active low
//   sample_valid    one-cycle strobe, sample_data just updated
//   sample_data     16*NUM_AXES bits of big-endian axis words
//   busy            burst in progress
//   overrun         sticky: trigger seen while busy
//   timeout         sticky: watchdog expired (watchdog build only)
// ---------------------------------------------------------------------------
module imu_burst_reader
  import imu_pkg::*;
#(
  parameter int unsigned NUM_AXES    = 3,
  parameter logic [7:0]  START_ADDR  = 8'h3B,
  parameter int unsigned CS_GUARD    = 4,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  output logic                     spi_start,
  output logic [7:0]               spi_tx,
  input  logic [7:0]               spi_rx,
  input  logic                     spi_busy,
  input  logic                     spi_done,
  output logic                     cs_n,
  output logic                     sample_valid,
  output logic [16*NUM_AXES-1:0]   sample_data,
  output logic                     busy,
  output logic                     overrun,
  output logic                     timeout
);

  localparam int unsigned DATA_W    = 16 * NUM_AXES;
  localparam int unsigned NUM_BYTES = 2 * NUM_AXES;
  localparam int unsigned BCNT_W    = $clog2(NUM_BYTES + 1);
  localparam int unsigned GCNT_W    = (CS_GUARD > 0) ? $clog2(CS_GUARD + 1) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NUM_BYTES - 1);

  imu_state_e          state_q;
  logic                cs_n_q;
  logic                spi_start_q;
  logic [7:0]          spi_tx_q;
  logic                sample_valid_q;
  logic [DATA_W-1:0]   sample_data_q;
  logic [DATA_W-1:0]   staging_q;
  logic                busy_q;
  logic                overrun_q;
  logic [BCNT_W-1:0]   byte_cnt_q;
  logic [GCNT_W-1:0]   guard_cnt_q;

  logic [DATA_W-1:0]   staging_d;
  logic [BCNT_W-1:0]   byte_cnt_d;
  logic [GCNT_W-1:0]   guard_cnt_d;
  logic                setup_guard_done;
  logic                hold_guard_done;

  // New bytes enter at the LSB end so the first byte lands in the MSBs.
  assign staging_d   = {staging_q[DATA_W-9:0], spi_rx};
  assign byte_cnt_d  = byte_cnt_q + BCNT_W'(1);
  assign guard_cnt_d = guard_cnt_q + GCNT_W'(1);

  // cs_n falls on the first CS_SETUP cycle and spi_start is registered, so
  // deciding on the CS_GUARD-th setup cycle puts spi_start CS_GUARD cycles
  // after the fall.
  assign setup_guard_done = (32'(guard_cnt_q) + 32'd1) >= CS_GUARD;
  // The hold guard starts the cycle after the last spi_done and cs_n is
  // registered, so one cycle fewer is spent in CS_HOLD.
  assign hold_guard_done  = (32'(guard_cnt_q) + 32'd2) >= CS_GUARD;

`ifdef IMU_BURST_READER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cs_n_q         <= 1'b1;
      spi_start_q    <= 1'b0;
      spi_tx_q       <= 8'h00;
      sample_valid_q <= 1'b0;
      sample_data_q  <= '0;
      staging_q      <= '0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      byte_cnt_q     <= '0;
      guard_cnt_q    <= '0;
`ifdef IMU_BURST_READER_TIMEOUT_EN
      wd_cnt_q       <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      spi_start_q    <= 1'b0;
      sample_valid_q <= 1'b0;

      // busy_q is high from CS_SETUP through PUBLISH, so a trigger in the
      // PUBLISH cycle is an overrun while the following IDLE cycle is not.
      if (trigger && busy_q) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q     <= ST_CS_SETUP;
            cs_n_q      <= 1'b0;
            busy_q      <= 1'b1;
            guard_cnt_q <= '0;
            byte_cnt_q  <= '0;
          end
        end

        ST_CS_SETUP: begin
          if (!setup_guard_done) begin
            guard_cnt_q <= guard_cnt_d;
          end else if (!spi_busy && !spi_done) begin
            // Hold off while the byte master is still occupied.
            spi_start_q <= 1'b1;
            spi_tx_q    <= imu_read_cmd(START_ADDR);
            state_q     <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          // Byte received during the command phase carries no data.
          if (spi_done) begin
            spi_start_q <= 1'b1;
            spi_tx_q    <= IMU_DUMMY_BYTE;
            state_q     <= ST_BYTE;
          end
        end

        ST_BYTE: begin
          if (spi_done) begin
            staging_q <= staging_d;
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q  <= '0;
              guard_cnt_q <= '0;
              if (CS_GUARD <= 1) begin
                cs_n_q  <= 1'b1;
                state_q <= ST_PUBLISH;
              end else begin
                state_q <= ST_CS_HOLD;
              end
            end else begin
              byte_cnt_q  <= byte_cnt_d;
              spi_start_q <= 1'b1;
              spi_tx_q    <= IMU_DUMMY_BYTE;
            end
          end
        end

        ST_CS_HOLD: begin
          if (hold_guard_done) begin
            cs_n_q  <= 1'b1;
            state_q <= ST_PUBLISH;
          end else begin
            guard_cnt_q <= guard_cnt_d;
          end
        end

        ST_PUBLISH: begin
          sample_data_q  <= staging_q;
          sample_valid_q <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase

`ifdef IMU_BURST_READER_TIMEOUT_EN
      // Reloading on spi_done gives a count of zero in the following
      // spi_start cycle, so expiry lands TIMEOUT_CYC cycles after spi_start.
      // These assignments follow the case so an abort overrides it.
      if (state_q == ST_ADDR || state_q == ST_BYTE) begin
        if (spi_done) begin
          wd_cnt_q <= '0;
        end else if (wd_cnt_q == WD_LAST) begin
          timeout_q  <= 1'b1;
          cs_n_q     <= 1'b1;
          busy_q     <= 1'b0;
          staging_q  <= '0;
          byte_cnt_q <= '0;
          state_q    <= ST_IDLE;
        end else begin
          wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end
      end else begin
        wd_cnt_q <= '0;
      end
`endif
    end
  end

  assign spi_start    = spi_start_q;
  assign spi_tx       = spi_tx_q;
  assign cs_n         = cs_n_q;
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

`ifdef IMU_BURST_READER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // Watchdog compiled out: constant low. TIMEOUT_CYC is folded in only so
  // the parameter is consumed in this build as well.
  assign timeout = 1'b0 & (TIMEOUT_CYC != 0);
`endif

endmodule
